alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle execute-stage ALU.
- Width, pipeline depth and operation set are generalised; status flags and a transaction tag are added.
- Uses a valid/ready handshake on both sides, with bubble collapsing and full backpressure.
- Sits between decode/issue and writeback in the EXE stage. The tag carries the destination register or ROB index through with each result.

Parameters:
- WIDTH, 32, operand/result width; power of two, range 8..64.
- STAGES, 2, number of register stages; range 1..4. Latency equals STAGES with no stalls.
- TAG_W, 5, width of the opaque tag passed alongside each operation.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has an operation
- in_ready  out  1  block accepts an operation this cycle
- command  in  4  operation code, type alu_op_t
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result available
- out_ready  in  1  downstream consumes the result
- result  out  WIDTH  operation result
- out_tag  out  TAG_W  tag of the result
- flag_zero  out  1  result == 0
- flag_carry  out  1  ADD carry-out; SUB borrow (in_a < in_b unsigned); 0 for all other ops
- flag_ovf  out  1  signed overflow for ADD/SUB; 0 for all other ops
- illegal_op  out  1  command was not a defined code

Behaviour:
- Reset is synchronous and active-high on one clock, clk. Reset clears every stage valid bit and sets result, out_tag and all flags to 0. out_valid = 0 in the cycle after reset is sampled high.
- Reset asserted mid-operation discards all in-flight operations. No output handshake occurs for them.
- Opcodes:
  - AND = 0, OR = 1, ADD = 2, SUB = 3, XOR = 4.
  - SLT = 5: signed compare, result 1 or 0, zero-extended.
  - SLTU = 6: unsigned compare, result 1 or 0, zero-extended.
  - SLL = 7, SRL = 8, SRA = 9.
  - Codes 10..15 compute ADD and set illegal_op = 1.
- Shift amount is in_b[$clog2(WIDTH)-1:0]; upper bits of in_b are ignored. Shifting by 0 returns in_a unchanged.
- All arithmetic is modulo 2^WIDTH.
- The operation is computed combinationally from the inputs and captured into stage 0 on input acceptance. Later stages only move data; no recomputation occurs.
- Input acceptance happens when in_valid && in_ready.
- Each stage k holds a valid bit and a payload {result, tag, flags, illegal}.
- Stage k loads from stage k-1 (or from the input, for k = 0) when it is empty or itself advancing this cycle.
- The last stage advances when out_ready = 1.
- in_ready = !v[0] || stage 0 advancing. This is combinational from out_ready through the chain, with no registered skid.
- Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- out_valid = v[STAGES-1]. The outputs are driven directly from the last stage's registers.
- While out_valid && !out_ready, all outputs hold stable for as many cycles as the stall lasts.
- Latency is exactly STAGES cycles from acceptance to out_valid when out_ready stays high.
- Throughput is 1 operation per cycle with no stalls. Capacity is STAGES operations in flight.
- Simultaneous accept into a stage and advance out of it in the same cycle is legal, with no loss and no duplication.
- Order is strictly in order; tags emerge in the same sequence they were accepted.
- When in_valid = 0, the command, operand and tag inputs are don't-care.

Decomposition:
- Add to package common:
  - alu_op_t, a 4-bit enum holding the opcodes above. It replaces the 3-bit command encoding; existing values 0..3 are unchanged.
  - alu_flags_t, a packed struct {zero, carry, ovf, illegal}.
  - ALU_NUM_OPS = 10.
- One sub-module, alu_core: purely combinational, parametrised by WIDTH. It maps (command, in_a, in_b) to (result, alu_flags_t).
- The alu_pipe top contains only the stage registers and handshake logic. alu_core can also be reused by the branch unit.

Test Plan:
- WIDTH = 32, STAGES = 2, out_ready = 1. Issue ADD 0x7FFFFFFF + 1 with tag 3. Expected, exactly 2 cycles later: result 0x80000000, ovf = 1, carry = 0, zero = 0, out_tag = 3.
- SUB 5 - 7. Expected: result 0xFFFFFFFE, carry (borrow) = 1. Then SLT 0xFFFFFFFF vs 1 gives 1, and SLTU of the same operands gives 0.
- SRA 0x80000000 by in_b = 0x21. Shift amount is 1, so result is 0xC0000000. SLL by 0 returns in_a unchanged.
- Test sequence:
  - Stream 6 back-to-back operations with tags 0..5.
  - Hold out_ready = 0 from cycle 3 to cycle 7.
  - Expected: in_ready drops once 2 operations are held, and outputs stay stable through the stall.
  - Expected: all 6 results emerge in order with no duplication.
- Command 12, in_a = 2, in_b = 3. Expected: result 5, illegal_op = 1.
- Assert reset for 1 cycle with 2 operations in flight. Expected: next cycle out_valid = 0, result = 0, in_ready = 1, and no stale output afterwards.

Source files
------------

// File: rtl/common.sv
// Shared types for the execute stage: ALU opcodes and status flags.
package common;

  localparam int ALU_NUM_OPS = 10;

  // Codes 0..3 keep their original 3-bit meaning; 10..15 are undefined.
  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLT  = 4'd5,
    OP_SLTU = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9
  } alu_op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic illegal;
  } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (command, in_a, in_b) -> (result, flags). Shared with the branch unit.
module alu_core
  import common::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          command,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic             add_ovf;
  logic             sub_ovf;

  always_comb begin
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    shamt   = in_b[SHW-1:0];
    add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
    sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);

    result        = '0;
    flags         = '0;
    flags.illegal = (int'(command) >= ALU_NUM_OPS);

    case (command)
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_SUB: begin
        result      = diff[WIDTH-1:0];
        flags.carry = diff[WIDTH];  // borrow, i.e. in_a < in_b unsigned
        flags.ovf   = sub_ovf;
      end
      OP_XOR:  result = in_a ^ in_b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      OP_SLL:  result = in_a << shamt;
      OP_SRL:  result = in_a >> shamt;
      OP_SRA:  result = $signed(in_a) >>> shamt;
      default: begin
        // OP_ADD and every undefined code
        result      = sum[WIDTH-1:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = add_ovf;
      end
    endcase

    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined EXE-stage ALU: compute on accept, then STAGES elastic register stages
// with bubble collapsing and full (combinational) backpressure.
module alu_pipe
  import common::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          command,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             illegal_op
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
    alu_flags_t       flags;
  } stage_t;

  logic [WIDTH-1:0]  core_result;
  alu_flags_t        core_flags;

  logic [STAGES-1:0] v_reg;
  stage_t            pl_reg [STAGES];
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_valid;
  stage_t            src_pl [STAGES];
  logic              go;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .command (command),
    .in_a    (in_a),
    .in_b    (in_b),
    .result  (core_result),
    .flags   (core_flags)
  );

  // A stage may load when it is empty or its content moves on this cycle;
  // the permission ripples back from out_ready in one combinational pass.
  always_comb begin
    load = '0;
    go   = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !v_reg[k] || go;
      go      = load[k];
    end
  end

  assign in_ready = load[0];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign src_valid[gi] = in_valid;
        assign src_pl[gi]    = '{result: core_result, tag: in_tag, flags: core_flags};
      end else begin : g_body
        assign src_valid[gi] = v_reg[gi-1];
        assign src_pl[gi]    = pl_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      v_reg <= '0;
      for (int k = 0; k < STAGES; k++) pl_reg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_reg[k] <= src_valid[k];
          if (src_valid[k]) pl_reg[k] <= src_pl[k];
        end
      end
    end
  end

  assign out_valid  = v_reg[STAGES-1];
  assign result     = pl_reg[STAGES-1].result;
  assign out_tag    = pl_reg[STAGES-1].tag;
  assign flag_zero  = pl_reg[STAGES-1].flags.zero;
  assign flag_carry = pl_reg[STAGES-1].flags.carry;
  assign flag_ovf   = pl_reg[STAGES-1].flags.ovf;
  assign illegal_op = pl_reg[STAGES-1].flags.illegal;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: arithmetic reference model + scoreboard queue,
// directed literal vectors, a stalled stream and a mid-flight reset.
module tb_alu_pipe;
  import common::*;

  localparam int W      = 32;
  localparam int STAGES = 2;
  localparam int TW     = 5;
  localparam longint SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam longint SMIN = -64'sh0000_0000_8000_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  alu_op_t       command = OP_AND;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic [TW-1:0] out_tag;
  logic          flag_zero, flag_carry, flag_ovf, illegal_op;

  alu_pipe #(.WIDTH(W), .STAGES(STAGES), .TAG_W(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .command    (command),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_tag    (out_tag),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  res;
    logic [3:0]    fl;   // {zero, carry, ovf, illegal}
    logic [TW-1:0] tag;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  bit            saw_block = 0;
  bit            stalled = 0;
  logic [W-1:0]  last_res;
  logic [TW-1:0] last_tag;
  logic [3:0]    last_fl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour in plain wide arithmetic.
  function automatic exp_t model(input logic [3:0] cmd, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic [TW-1:0] tag);
    exp_t   r;
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    longint v  = 0;
    logic signed [W-1:0] sgn = a;
    int     sh = int'(b[4:0]);
    logic   carry = 1'b0;
    logic   ovf = 1'b0;
    case (cmd)
      4'd0: v = ua & ub;
      4'd1: v = ua | ub;
      4'd3: begin
        v = ua - ub; carry = (ua < ub);
        ovf = ((sa - sb) > SMAX) || ((sa - sb) < SMIN);
      end
      4'd4: v = ua ^ ub;
      4'd5: v = (sa < sb) ? 1 : 0;
      4'd6: v = (ua < ub) ? 1 : 0;
      4'd7: v = longint'({32'd0, a << sh});
      4'd8: v = longint'({32'd0, a >> sh});
      4'd9: v = longint'({32'd0, sgn >>> sh});
      default: begin
        v = ua + ub; carry = (v > 64'sh0000_0000_FFFF_FFFF);
        ovf = ((sa + sb) > SMAX) || ((sa + sb) < SMIN);
      end
    endcase
    r.res = v[W-1:0];
    r.fl  = {(v[W-1:0] == '0), carry, ovf, (cmd >= 4'd10)};
    r.tag = tag;
    return r;
  endfunction

  // Compare process: samples on the falling edge, mid-way between active edges.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      stalled = 0;
    end else begin
      chk("in_ready", in_ready, (int'(q.size()) < STAGES) || out_ready);
      if (!in_ready && in_valid) saw_block = 1;
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_result", result, last_res);
        chk("stall_tag", out_tag, last_tag);
        chk("stall_flags", {flag_zero, flag_carry, flag_ovf, illegal_op}, last_fl);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("stale_out_valid", out_valid, 0);
        end else if (out_ready) begin
          e = q.pop_front();
          $display("txn tag=%0d result=%08h flags=%04b", out_tag, result,
                   {flag_zero, flag_carry, flag_ovf, illegal_op});
          chk("model_result", result, e.res);
          chk("model_tag", out_tag, e.tag);
          chk("model_flags", {flag_zero, flag_carry, flag_ovf, illegal_op}, e.fl);
        end
      end
      stalled  = out_valid && !out_ready;
      last_res = result;
      last_tag = out_tag;
      last_fl  = {flag_zero, flag_carry, flag_ovf, illegal_op};
      if (in_valid && in_ready) q.push_back(model(command, in_a, in_b, in_tag));
    end
  end

  // Drive one operation and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic put(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [TW-1:0] tag);
    int n = 0;
    in_valid = 1'b1;
    command  = alu_op_t'(cmd);
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (n >= 30) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Single op with literal expectations and exact latency STAGES.
  task automatic single(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input logic [W-1:0] exp_res,
                        input logic [3:0] exp_fl);
    put(cmd, a, b, tag);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_early", out_valid, 0);
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("lit_result", result, exp_res);
    chk("lit_tag", out_tag, tag);
    chk("lit_flags", {flag_zero, flag_carry, flag_ovf, illegal_op}, exp_fl);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_flags", {flag_zero, flag_carry, flag_ovf, illegal_op}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Directed literal vectors: {zero, carry, ovf, illegal}
    single(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3,  32'h8000_0000, 4'b0010);
    single(4'd3, 32'd5,         32'd7,         5'd4,  32'hFFFF_FFFE, 4'b0100);
    single(4'd5, 32'hFFFF_FFFF, 32'd1,         5'd5,  32'h0000_0001, 4'b0000);
    single(4'd6, 32'hFFFF_FFFF, 32'd1,         5'd6,  32'h0000_0000, 4'b1000);
    single(4'd9, 32'h8000_0000, 32'h0000_0021, 5'd7,  32'hC000_0000, 4'b0000);
    single(4'd7, 32'h1234_5678, 32'h0000_0000, 5'd8,  32'h1234_5678, 4'b0000);
    single(4'd12, 32'd2,        32'd3,         5'd9,  32'h0000_0005, 4'b0001);
    single(4'd2, 32'hFFFF_FFFF, 32'd1,         5'd10, 32'h0000_0000, 4'b1100);
    single(4'd8, 32'hF000_0000, 32'h0000_0104, 5'd11, 32'h0F00_0000, 4'b0000);

    // Stream of 6 back-to-back ops with a downstream stall
    fork
      begin
        for (int i = 0; i < 6; i++)
          put(4'(i + 2), 32'h9000_0000 + 32'(i * 7), 32'(i + 1), 5'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    n = 0;
    while (q.size() != 0 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("stream_drained", q.size(), 0);
    chk("stream_backpressure_seen", saw_block, 1);
    @(posedge clk);
    #1;

    // Reset with two operations in flight
    out_ready = 1'b0;
    put(4'd2, 32'd10, 32'd20, 5'd20);
    put(4'd4, 32'hAAAA_0000, 32'h0000_5555, 5'd21);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
